// File: rtl/cw_pkg.sv
// Shared types and constants for the CW symbol decoder.
package cw_pkg;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_COLLECT    = 2'd1,
    S_EMIT_CHAR  = 2'd2,
    S_EMIT_SPACE = 2'd3
  } cw_state_t;

  typedef struct packed {
    logic dot;
    logic dash;
    logic char_sp;
    logic word_sp;
  } cw_edges_t;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam int         FIFO_DEPTH  = 4;
  localparam int         MAX_SYM_LEN = 6;

endpackage

// File: rtl/cw_morse_lut.sv
// Morse lookup: element n lives in pattern bit n, dash = 1.
module cw_morse_lut (
  input  logic [2:0] len,
  input  logic [5:0] pattern,
  output logic [7:0] ascii,
  output logic       hit
);

  always_comb begin
    ascii = 8'h00;
    hit   = 1'b1;
    case ({len, pattern})
      {3'd2, 6'b000010}: ascii = 8'h41;
      {3'd4, 6'b000001}: ascii = 8'h42;
      {3'd4, 6'b000101}: ascii = 8'h43;
      {3'd3, 6'b000001}: ascii = 8'h44;
      {3'd1, 6'b000000}: ascii = 8'h45;
      {3'd4, 6'b000100}: ascii = 8'h46;
      {3'd3, 6'b000011}: ascii = 8'h47;
      {3'd4, 6'b000000}: ascii = 8'h48;
      {3'd2, 6'b000000}: ascii = 8'h49;
      {3'd4, 6'b001110}: ascii = 8'h4A;
      {3'd3, 6'b000101}: ascii = 8'h4B;
      {3'd4, 6'b000010}: ascii = 8'h4C;
      {3'd2, 6'b000011}: ascii = 8'h4D;
      {3'd2, 6'b000001}: ascii = 8'h4E;
      {3'd3, 6'b000111}: ascii = 8'h4F;
      {3'd4, 6'b000110}: ascii = 8'h50;
      {3'd4, 6'b001011}: ascii = 8'h51;
      {3'd3, 6'b000010}: ascii = 8'h52;
      {3'd3, 6'b000000}: ascii = 8'h53;
      {3'd1, 6'b000001}: ascii = 8'h54;
      {3'd3, 6'b000100}: ascii = 8'h55;
      {3'd4, 6'b001000}: ascii = 8'h56;
      {3'd3, 6'b000110}: ascii = 8'h57;
      {3'd4, 6'b001001}: ascii = 8'h58;
      {3'd4, 6'b001101}: ascii = 8'h59;
      {3'd4, 6'b000011}: ascii = 8'h5A;
      {3'd5, 6'b011111}: ascii = 8'h30;
      {3'd5, 6'b011110}: ascii = 8'h31;
      {3'd5, 6'b011100}: ascii = 8'h32;
      {3'd5, 6'b011000}: ascii = 8'h33;
      {3'd5, 6'b010000}: ascii = 8'h34;
      {3'd5, 6'b000000}: ascii = 8'h35;
      {3'd5, 6'b000001}: ascii = 8'h36;
      {3'd5, 6'b000011}: ascii = 8'h37;
      {3'd5, 6'b000111}: ascii = 8'h38;
      {3'd5, 6'b001111}: ascii = 8'h39;
      default:           hit   = 1'b0;
    endcase
  end

endmodule

// File: rtl/cw_symbol_decoder.sv
// CW element/gap stream to ASCII characters, buffered in a
// small output FIFO.
module cw_symbol_decoder
  import cw_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       dot_inp,
  input  logic       dash_inp,
  input  logic       char_space_inp,
  input  logic       word_space_inp,
  output logic [7:0] char_out,
  output logic       char_valid,
  input  logic       char_ready,
  output logic       sym_error,
  output logic       overflow
);

  localparam logic [2:0] LEN_MAX = 3'(MAX_SYM_LEN);
  localparam logic [2:0] CNT_MAX = 3'(FIFO_DEPTH);

  cw_state_t  state;
  cw_edges_t  prev;
  cw_edges_t  edges;
  logic [5:0] pattern;
  logic [2:0] len;
  logic       too_long;
  logic       space_pend;

  logic [5:0] app_pattern;
  logic [2:0] app_len;
  logic       app_long;
  logic       elem;
  logic       gap;

  logic [7:0] lut_ascii;
  logic       lut_hit;
  logic       bad_sym;
  logic       push;
  logic [7:0] push_data;

  logic [7:0] mem [FIFO_DEPTH];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;
  logic       pop;
  logic       full;
  logic       do_push;

  cw_morse_lut u_lut (
    .len     (len),
    .pattern (pattern),
    .ascii   (lut_ascii),
    .hit     (lut_hit)
  );

  assign edges.dot     = dot_inp & ~prev.dot;
  assign edges.dash    = dash_inp & ~prev.dash;
  assign edges.char_sp = char_space_inp & ~prev.char_sp;
  assign edges.word_sp = word_space_inp & ~prev.word_sp;

  assign elem    = edges.dot | edges.dash;
  assign gap     = edges.char_sp | edges.word_sp;
  assign bad_sym = too_long | ~lut_hit;

  // Symbol state after appending the current element.
  always_comb begin
    app_pattern = pattern;
    app_len     = len;
    app_long    = too_long;
    if (len == LEN_MAX) begin
      app_long = 1'b1;
    end else begin
      app_pattern[len] = edges.dash;
      app_len          = len + 3'd1;
    end
  end

  always_comb begin
    push      = 1'b0;
    push_data = ASCII_SPACE;
    case (state)
      S_EMIT_CHAR: begin
        push      = 1'b1;
        push_data = bad_sym ? ASCII_QMARK : lut_ascii;
      end
      S_EMIT_SPACE: push = 1'b1;
      S_IDLE:       push = edges.word_sp & ~elem;
      default:      push = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      prev       <= '0;
      pattern    <= '0;
      len        <= '0;
      too_long   <= 1'b0;
      space_pend <= 1'b0;
      sym_error  <= 1'b0;
    end else begin
      prev      <= {dot_inp, dash_inp, char_space_inp, word_space_inp};
      sym_error <= 1'b0;
      case (state)
        S_IDLE, S_COLLECT: begin
          if (elem) begin
            pattern  <= app_pattern;
            len      <= app_len;
            too_long <= app_long;
          end
          if ((elem || state == S_COLLECT) && gap) begin
            state      <= S_EMIT_CHAR;
            space_pend <= edges.word_sp;
          end else if (elem) begin
            state <= S_COLLECT;
          end
        end
        S_EMIT_CHAR: begin
          sym_error <= bad_sym;
          pattern   <= '0;
          len       <= '0;
          too_long  <= 1'b0;
          state     <= space_pend ? S_EMIT_SPACE : S_IDLE;
        end
        S_EMIT_SPACE: begin
          space_pend <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign char_valid = (count != 3'd0);
  assign char_out   = mem[rd_ptr];
  assign pop        = char_valid & char_ready;
  assign full       = (count == CNT_MAX);
  // A pop frees the slot this cycle, so a full FIFO still takes the push.
  assign do_push    = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'h00;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push && !do_push) overflow <= 1'b1;
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      case ({do_push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_cw_symbol_decoder.sv
// Directed and randomized checks of cw_symbol_decoder against a
// string-level Morse model.
module tb_cw_symbol_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       dot_inp;
  logic       dash_inp;
  logic       char_space_inp;
  logic       word_space_inp;
  logic [7:0] char_out;
  logic       char_valid;
  logic       char_ready;
  logic       sym_error;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  bit         mon_en = 1'b0;
  logic [7:0] exp_q[$];
  int         err_exp  = 0;
  int         err_seen = 0;

  string      morse[36] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
    ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
    "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
    "-----", ".----", "..---", "...--", "....-", ".....", "-....",
    "--...", "---..", "----."
  };
  logic [7:0] table_lut[string];
  string      cur;
  bit         m_long;

  cw_symbol_decoder dut (
    .clk            (clk),
    .rst            (rst),
    .dot_inp        (dot_inp),
    .dash_inp       (dash_inp),
    .char_space_inp (char_space_inp),
    .word_space_inp (word_space_inp),
    .char_out       (char_out),
    .char_valid     (char_valid),
    .char_ready     (char_ready),
    .sym_error      (sym_error),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [7:0] e;
    @(posedge clk);
    #1;
    if (mon_en) begin
      if (sym_error) err_seen++;
      if (char_valid && char_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        chk("rand_pop", {24'h0, char_out}, {24'h0, e});
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // 0 dot, 1 dash, 2 char_space, 3 word_space
  task automatic pulse(input int which);
    case (which)
      0: dot_inp = 1'b1;
      1: dash_inp = 1'b1;
      2: char_space_inp = 1'b1;
      default: word_space_inp = 1'b1;
    endcase
    tick();
    dot_inp = 1'b0;
    dash_inp = 1'b0;
    char_space_inp = 1'b0;
    word_space_inp = 1'b0;
    tick();
  endtask

  task automatic model_elem(input bit is_dash);
    if (cur.len() == 6) m_long = 1'b1;
    else cur = {cur, is_dash ? "-" : "."};
  endtask

  task automatic model_gap(input bit word);
    if (cur.len() > 0) begin
      if (m_long || !table_lut.exists(cur)) begin
        exp_q.push_back(8'h3F);
        err_exp++;
      end else begin
        exp_q.push_back(table_lut[cur]);
      end
      cur = "";
      m_long = 1'b0;
    end
    if (word) exp_q.push_back(8'h20);
  endtask

  task automatic send_e();
    pulse(0);
    pulse(2);
    ticks(2);
  endtask

  initial begin
    int    n;
    int    idx;
    string s;
    for (int i = 0; i < 26; i++) table_lut[morse[i]] = 8'h41 + 8'(i);
    for (int i = 0; i < 10; i++) table_lut[morse[26+i]] = 8'h30 + 8'(i);
    cur    = "";
    m_long = 1'b0;

    rst = 1'b0;
    dot_inp = 1'b0;
    dash_inp = 1'b0;
    char_space_inp = 1'b0;
    word_space_inp = 1'b0;
    char_ready = 1'b0;
    ticks(2);
    chk("rst_valid", {31'h0, char_valid}, 32'd0);
    chk("rst_out", {24'h0, char_out}, 32'h00);
    chk("rst_err", {31'h0, sym_error}, 32'd0);
    chk("rst_ovf", {31'h0, overflow}, 32'd0);
    rst = 1'b1;
    tick();

    // A with latency check
    pulse(0);
    pulse(1);
    char_space_inp = 1'b1;
    tick();
    chk("a_lat1", {31'h0, char_valid}, 32'd0);
    tick();
    chk("a_lat2", {31'h0, char_valid}, 32'd1);
    chk("a_char", {24'h0, char_out}, 32'h41);
    chk("a_err", {31'h0, sym_error}, 32'd0);
    char_space_inp = 1'b0;
    char_ready = 1'b1;
    tick();
    char_ready = 1'b0;
    chk("a_empty", {31'h0, char_valid}, 32'd0);

    // B then space
    pulse(1);
    pulse(0);
    pulse(0);
    pulse(0);
    pulse(3);
    tick();
    chk("b_valid", {31'h0, char_valid}, 32'd1);
    chk("b_char", {24'h0, char_out}, 32'h42);
    char_ready = 1'b1;
    tick();
    chk("b_space", {24'h0, char_out}, 32'h20);
    chk("b_valid2", {31'h0, char_valid}, 32'd1);
    tick();
    chk("b_empty", {31'h0, char_valid}, 32'd0);
    char_ready = 1'b0;

    // too long
    for (int i = 0; i < 7; i++) pulse(0);
    pulse(2);
    chk("long_err", {31'h0, sym_error}, 32'd1);
    chk("long_char", {24'h0, char_out}, 32'h3F);
    tick();
    chk("long_pulse", {31'h0, sym_error}, 32'd0);
    char_ready = 1'b1;
    tick();
    char_ready = 1'b0;
    send_e();
    chk("long_next", {24'h0, char_out}, 32'h45);
    char_ready = 1'b1;
    tick();
    char_ready = 1'b0;

    // overflow
    for (int i = 0; i < 4; i++) send_e();
    chk("ovf_valid", {31'h0, char_valid}, 32'd1);
    chk("ovf_clear", {31'h0, overflow}, 32'd0);
    send_e();
    chk("ovf_set", {31'h0, overflow}, 32'd1);
    char_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ovf_drain", {23'h0, char_valid, char_out}, {23'h0, 1'b1, 8'h45});
      tick();
    end
    chk("ovf_empty", {31'h0, char_valid}, 32'd0);
    chk("ovf_sticky", {31'h0, overflow}, 32'd1);
    char_ready = 1'b0;

    // held char_space level
    pulse(1);
    char_space_inp = 1'b1;
    ticks(10);
    char_space_inp = 1'b0;
    ticks(2);
    chk("hold_char", {23'h0, char_valid, char_out}, {23'h0, 1'b1, 8'h54});
    char_ready = 1'b1;
    tick();
    chk("hold_once", {31'h0, char_valid}, 32'd0);
    char_ready = 1'b0;

    // reset mid-symbol with a queued char
    send_e();
    pulse(0);
    pulse(1);
    rst = 1'b0;
    tick();
    chk("mrst_valid", {31'h0, char_valid}, 32'd0);
    chk("mrst_out", {24'h0, char_out}, 32'h00);
    chk("mrst_ovf", {31'h0, overflow}, 32'd0);
    rst = 1'b1;
    pulse(2);
    ticks(3);
    chk("mrst_nopush", {31'h0, char_valid}, 32'd0);

    // randomized symbols against the model
    char_ready = 1'b1;
    mon_en = 1'b1;
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        n = $urandom_range(2, 3);
        model_gap(n == 3);
        pulse(n);
        ticks(2);
      end
      if ($urandom_range(0, 1) == 1) begin
        idx = $urandom_range(0, 35);
        s = morse[idx];
        for (int j = 0; j < s.len(); j++) begin
          model_elem(s[j] == "-");
          pulse((s[j] == "-") ? 1 : 0);
        end
      end else begin
        n = $urandom_range(1, 7);
        for (int j = 0; j < n; j++) begin
          idx = $urandom_range(0, 1);
          model_elem(idx == 1);
          pulse(idx);
        end
      end
      n = ($urandom_range(0, 9) < 7) ? 2 : 3;
      model_gap(n == 3);
      pulse(n);
      ticks(2);
    end
    ticks(4);
    mon_en = 1'b0;
    chk("rand_left", exp_q.size(), 32'd0);
    chk("rand_errs", err_seen, err_exp);
    chk("rand_ovf", {31'h0, overflow}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cw_symbol_decoder.md
CW_SYMBOL_DECODER -- requirements
Module: cw_symbol_decoder

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; all logic on its rising edge.
REQ-002 SHALL have: rst  in  1  reset, synchronous, active-low; clock clk.
REQ-003 SHALL have: dot_inp  in  1  dot element level from the upstream CW receiver.
REQ-004 SHALL have: dash_inp  in  1  dash element level from the upstream CW receiver.
REQ-005 SHALL have: char_space_inp  in  1  inter-character gap level; the input may stay high for several cycles.
REQ-006 SHALL have: word_space_inp  in  1  inter-word gap level.
REQ-007 SHALL have: char_out  out  8  ASCII code at the FIFO head.
REQ-008 SHALL have: char_valid  out  1  high when the FIFO is non-empty.
REQ-009 SHALL have: char_ready  in  1  consumer accept; a pop occurs when char_valid and char_ready are both high.
REQ-010 SHALL have: sym_error  out  1  one-cycle pulse when a symbol is too long or unknown.
REQ-011 SHALL have: overflow  out  1  sticky flag; set when a push is dropped, cleared only by reset.

Function
REQ-012 SHALL rising-edge-detect all four element/gap inputs with registered previous values; a level held high counts as one event only.
REQ-013 SHALL accumulate elements in pattern[5:0] and len[2:0]:
- element n (n = 0 first) is written to bit n; dash = 1, dot = 0.
- len increments by 1 per element.
REQ-014 SHALL, on a 7th element (len == 6), stop storing elements, set the internal too_long flag, and hold len at 6.
REQ-015 SHALL use states IDLE (len == 0), COLLECT, EMIT_CHAR and EMIT_SPACE:
- IDLE -> COLLECT on the first element.
- COLLECT -> EMIT_CHAR on a char_space edge.
- COLLECT -> EMIT_CHAR on a word_space edge, with space_pend set.
- EMIT_CHAR -> EMIT_SPACE if space_pend is set, otherwise -> IDLE.
- EMIT_SPACE -> IDLE.
REQ-016 SHALL, in EMIT_CHAR:
- push the lookup result, or 0x3F '?' if too_long is set or the lookup misses;
- pulse sym_error in that case;
- clear pattern, len and too_long.
REQ-017 SHALL push 0x20 in EMIT_SPACE.
REQ-018 SHALL push 0x20 directly from IDLE on a word_space edge.
REQ-019 SHALL ignore a char_space edge received in IDLE (empty symbol); no push occurs.
REQ-020 SHALL ignore an element edge arriving in EMIT_CHAR or EMIT_SPACE.
REQ-021 SHALL, when an element edge and a gap edge arrive in the same cycle in COLLECT, append the element first and include it in the emitted symbol.
REQ-022 SHALL cover A-Z (0x41-0x5A) and 0-9 (0x30-0x39) in the lookup, indexed by {len, pattern}.
REQ-023 SHALL implement a 4-entry output FIFO:
- 2-bit read and write pointers that wrap from 3 to 0;
- 3-bit count;
- char_out driven from the head entry.
REQ-024 SHALL, on a push while the FIFO is full with no pop in the same cycle, drop the push and set overflow.
REQ-025 SHALL accept a simultaneous push and pop in any FIFO state, including full; count is unchanged in that cycle.
REQ-026 SHALL allow a pop when empty to have no effect; char_valid stays low.
REQ-027 SHALL have a latency of 2 clk from the gap edge at the input pin to char_valid high with an empty FIFO.

Reset
REQ-028 SHALL, while rst = 0 at a clk edge:
- set char_valid, sym_error and overflow to 0;
- set char_out to 0x00;
- set state to IDLE;
- set pattern, len, too_long, space_pend, FIFO pointers, count and edge registers to 0.
REQ-029 SHALL, on reset mid-symbol or with a non-empty FIFO, discard all pending data; the first cycle after release behaves as a fresh IDLE.

Structure
REQ-030 SHALL place the following in the shared cw package:
- state encodings;
- ASCII constants (0x20, 0x3F);
- FIFO depth 4;
- maximum symbol length 6.
REQ-031 SHALL implement the lookup as a single combinational sub-module, cw_morse_lut, with inputs len and pattern and outputs ascii and hit.

Verification
REQ-032 SHALL test dot, dash, char_space -> one push of 0x41 'A'; char_valid is high 2 clk after the char_space edge.
REQ-033 SHALL test dash, dot, dot, dot, word_space -> 0x42 'B' then 0x20, in order, on consecutive pops.
REQ-034 SHALL test seven dots, char_space -> 0x3F with a one-cycle sym_error pulse; len is 0 afterwards.
REQ-035 SHALL test five 'E' symbols (dot, char_space) with char_ready = 0:
- four entries are held and char_valid = 1;
- the fifth push is dropped and overflow = 1;
- draining then yields 0x45 four times.
REQ-036 SHALL test a char_space level held for 10 clk after 'T' (dash) -> exactly one 0x54 push.
REQ-037 SHALL test rst = 0 asserted after dot, dash with no gap -> outputs reset; a following char_space yields no push.
